ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 DW, 8, data width of the RAM and both requester ports.
REQ-002 AW, 8, address width of the RAM and both requester ports.
REQ-003 DEPTH, 32, number of valid RAM words; addresses >= DEPTH are illegal.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 req_a / req_b  in  1  access request from requester A / B; held until granted.
REQ-007 we_a / we_b  in  1  1 = write, 0 = read; valid while req is high.
REQ-008 addr_a / addr_b  in  AW  word address; valid while req is high.
REQ-009 wdata_a / wdata_b  in  DW  write data; valid while req is high.
REQ-010 gnt_a / gnt_b  out  1  one-cycle pulse; the request is accepted and may be dropped or changed next cycle.
REQ-011 rvalid_a / rvalid_b  out  1  one-cycle pulse; rdata_x holds the read result.
REQ-012 rdata_a / rdata_b  out  DW  read result; holds its last value between pulses.
REQ-013 err_a / err_b  out  1  one-cycle pulse; an illegal address was rejected instead of granted.
REQ-014 ram_cs, ram_read, ram_write  out  1  RAM control; all registered.
REQ-015 ram_addr  out  AW  RAM address; registered.
REQ-016 ram_wdata  out  DW  RAM write data; registered.
REQ-017 ram_rdata  in  DW  RAM read data; valid in the cycle after the RAM samples a read.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RDWAIT, and SHALL accept a request only in IDLE.
REQ-019 In IDLE with any req high, the arbiter SHALL pick a winner, register its command, and enter ACCESS on the next cycle.
REQ-020 Arbitration SHALL be two-way round-robin: when both requests are high, the winner is the requester not granted most recently; after reset, A wins the first tie.
REQ-021 In ACCESS, ram_cs SHALL be 1, exactly one of ram_read and ram_write SHALL be 1 (per we), and gnt_x SHALL pulse for the winner.
REQ-022 A write SHALL return from ACCESS to IDLE, occupying 2 cycles from sample to IDLE.
REQ-023 A read SHALL go ACCESS -> RDWAIT -> IDLE; in RDWAIT the arbiter SHALL capture ram_rdata into rdata_x.
REQ-024 For a read, rvalid_x SHALL pulse in the cycle after RDWAIT, so read latency from the IDLE sample to rvalid is 3 cycles.
REQ-025 In IDLE and RDWAIT, ram_cs, ram_read and ram_write SHALL all be 0.
REQ-026 ram_cs SHALL never be asserted with both ram_read and ram_write set.
REQ-027 If the winning address is >= DEPTH, the arbiter SHALL pulse err_x in the cycle after the sample, issue no RAM access, and stay in IDLE.
REQ-028 An illegal-address rejection SHALL still update the round-robin pointer.
REQ-029 A request that rises while the FSM is busy SHALL be evaluated on the first IDLE cycle and SHALL never be lost.
REQ-030 rvalid_x for the previous read SHALL be able to coincide with an IDLE sample; back-to-back operation SHALL be supported.
REQ-031 No more than one of gnt_a/gnt_b, rvalid_a/rvalid_b and err_a/err_b SHALL be high in any cycle.

Reset
REQ-032 While reset is high: state = IDLE, all gnt/rvalid/err = 0, all ram_* outputs = 0, rdata_a/b = 0, and the round-robin pointer favours A.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no gnt, rvalid or err pulse afterwards; a write already issued to the RAM is not undone.

Structure
REQ-034 A shared package ram_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RDWAIT) and the DEPTH/DW/AW default constants.
REQ-035 Winner selection SHALL live in one sub-module, rr_arb2 (2-way round-robin picker with pointer update enable), instantiated once.

Verification
REQ-036 Write then read: A writes 0x5A to address 3, then reads address 3 -> gnt_a at cycle +1, rvalid_a at +3 after the read sample, rdata_a = 0x5A.
REQ-037 Tie: both requesters read continuously, starting after reset -> grants alternate A, B, A, B; each rvalid carries its own address's data.
REQ-038 Illegal address: B reads address 32 -> err_b pulses once, ram_cs stays 0, no gnt_b, no rvalid_b.
REQ-039 Reset mid-read: reset asserted during RDWAIT -> no rvalid, all outputs 0, and the next tie is granted to A.
REQ-040 Late request: req_b rises during A's read ACCESS -> gnt_b on the first ACCESS after A returns to IDLE; B's write 0xFF to address 31 reads back 0xFF.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_AW    = 8;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the pointer only moves when the caller commits a pick.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    output logic pick_a,
    output logic pick_b
);

    logic prefer_b_q;
    logic prefer_b_d;

    // On a tie the pointer decides; afterwards it favours whoever lost.
    always_comb begin
        pick_b     = req_b && (!req_a || prefer_b_q);
        pick_a     = req_a && !pick_b;
        prefer_b_d = prefer_b_q;
        if (update && (pick_a || pick_b)) begin
            prefer_b_d = pick_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_b_q <= 1'b0;
        end else begin
            prefer_b_q <= prefer_b_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one synchronous single-port RAM with registered controls.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int AW    = DEFAULT_AW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          err_a,
    output logic          err_b,
    output logic          ram_cs,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_t    state_q, state_d;
    logic          owner_b_q, owner_b_d;
    logic          gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic          err_a_q, err_a_d, err_b_q, err_b_d;
    logic          rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic          ram_cs_q, ram_cs_d, ram_read_q, ram_read_d, ram_write_q, ram_write_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;

    logic          pick_a, pick_b, arb_update;
    logic          sel_we, sel_illegal;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req_a  (req_a),
        .req_b  (req_b),
        .update (arb_update),
        .pick_a (pick_a),
        .pick_b (pick_b)
    );

    // The cycle carrying an err pulse is not sampled, so the rejected requester can withdraw.
    always_comb begin
        sel_we      = pick_b ? we_b : we_a;
        sel_addr    = pick_b ? addr_b : addr_a;
        sel_wdata   = pick_b ? wdata_b : wdata_a;
        sel_illegal = int'(sel_addr) >= DEPTH;
        arb_update  = (state_q == IDLE) && !err_a_q && !err_b_q && (req_a || req_b);
    end

    always_comb begin
        state_d     = state_q;
        owner_b_d   = owner_b_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        err_a_d     = 1'b0;
        err_b_d     = 1'b0;
        rvalid_a_d  = 1'b0;
        rvalid_b_d  = 1'b0;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        ram_cs_d    = 1'b0;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                if (arb_update) begin
                    owner_b_d = pick_b;
                    if (sel_illegal) begin
                        err_a_d = pick_a;
                        err_b_d = pick_b;
                    end else begin
                        state_d     = ACCESS;
                        gnt_a_d     = pick_a;
                        gnt_b_d     = pick_b;
                        ram_cs_d    = 1'b1;
                        ram_read_d  = !sel_we;
                        ram_write_d = sel_we;
                        ram_addr_d  = sel_addr;
                        ram_wdata_d = sel_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = ram_read_q ? RDWAIT : IDLE;
            end
            RDWAIT: begin
                state_d = IDLE;
                if (owner_b_q) begin
                    rdata_b_d  = ram_rdata;
                    rvalid_b_d = 1'b1;
                end else begin
                    rdata_a_d  = ram_rdata;
                    rvalid_a_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_b_q   <= 1'b0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            err_a_q     <= 1'b0;
            err_b_q     <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            ram_cs_q    <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_b_q   <= owner_b_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            err_a_q     <= err_a_d;
            err_b_q     <= err_b_d;
            rvalid_a_q  <= rvalid_a_d;
            rvalid_b_q  <= rvalid_b_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            ram_cs_q    <= ram_cs_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
    assign rvalid_a  = rvalid_a_q;
    assign rvalid_b  = rvalid_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign ram_cs    = ram_cs_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, transaction-schedule reference model and directed scenarios.
module tb_ram_arbiter;

    logic       clk;
    logic       reset;
    logic       req_a, we_a, req_b, we_b;
    logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b;
    logic [7:0] rdata_a, rdata_b;
    logic       ram_cs, ram_read, ram_write;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .req_b     (req_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .rvalid_a  (rvalid_a),
        .rvalid_b  (rvalid_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .err_a     (err_a),
        .err_b     (err_b),
        .ram_cs    (ram_cs),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_word(input int i);
        return 8'(i) ^ 8'hA5;
    endfunction

    // Synchronous RAM: data for a read appears in the cycle after it is sampled.
    logic [7:0] ram_mem [32];
    bit         ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 32; i++) ram_mem[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            if (ram_cs && ram_write) ram_mem[ram_addr[4:0]] <= ram_wdata;
            if (ram_cs && ram_read) ram_rdata <= ram_mem[ram_addr[4:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: each accepted request schedules its visible events at fixed cycle offsets.
    typedef struct {
        int         stamp;
        bit         rst;
        bit         gnt_a, gnt_b, err_a, err_b, rv_a, rv_b, cs, rd, wr;
        logic [7:0] addr, wdata, rdata;
    } slot_t;

    slot_t      ring [8];
    logic [7:0] model_mem [32];
    bit         model_loaded = 1'b0;
    bit         started = 1'b0;
    bit         prio_b = 1'b0;
    int         idle_from = 0;
    bit         m_win_b, m_we;
    logic [7:0] m_addr, m_wdata;
    int         m_idx;

    task automatic open_slot(input int at);
        if (ring[at % 8].stamp != at) ring[at % 8] = '{stamp: at, default: 0};
    endtask

    always @(posedge clk) begin
        if (!model_loaded) begin
            for (int i = 0; i < 32; i++) model_mem[i] = init_word(i);
            for (int i = 0; i < 8; i++) ring[i] = '{stamp: -1, default: 0};
            model_loaded = 1'b1;
        end
        if (reset) begin
            started   = 1'b1;
            prio_b    = 1'b0;
            idle_from = cyc + 1;
            ring[(cyc + 1) % 8] = '{stamp: cyc + 1, rst: 1'b1, default: 0};
            ring[(cyc + 2) % 8].stamp = -1;
            ring[(cyc + 3) % 8].stamp = -1;
        end else if (started && cyc >= idle_from && (req_a || req_b)) begin
            m_win_b = (req_a && req_b) ? prio_b : req_b;
            prio_b  = !m_win_b;
            m_we    = m_win_b ? we_b : we_a;
            m_addr  = m_win_b ? addr_b : addr_a;
            m_wdata = m_win_b ? wdata_b : wdata_a;
            open_slot(cyc + 1);
            m_idx = (cyc + 1) % 8;
            if (m_addr >= 8'd32) begin
                if (m_win_b) ring[m_idx].err_b = 1'b1;
                else ring[m_idx].err_a = 1'b1;
                idle_from = cyc + 2;
            end else begin
                if (m_win_b) ring[m_idx].gnt_b = 1'b1;
                else ring[m_idx].gnt_a = 1'b1;
                ring[m_idx].cs    = 1'b1;
                ring[m_idx].rd    = !m_we;
                ring[m_idx].wr    = m_we;
                ring[m_idx].addr  = m_addr;
                ring[m_idx].wdata = m_wdata;
                if (m_we) begin
                    model_mem[m_addr[4:0]] = m_wdata;
                    idle_from = cyc + 2;
                end else begin
                    open_slot(cyc + 3);
                    m_idx = (cyc + 3) % 8;
                    if (m_win_b) ring[m_idx].rv_b = 1'b1;
                    else ring[m_idx].rv_a = 1'b1;
                    ring[m_idx].rdata = model_mem[m_addr[4:0]];
                    idle_from = cyc + 3;
                end
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison of every output against the model schedule.
    logic [7:0] cmp_rdata_a = '0;
    logic [7:0] cmp_rdata_b = '0;
    slot_t      cmp_s;
    bit         cmp_have;
    always @(negedge clk) begin
        if (started) begin
            cmp_s    = ring[cyc % 8];
            cmp_have = (cmp_s.stamp == cyc);
            if (!cmp_have) cmp_s = '{stamp: cyc, default: 0};
            if (cmp_s.rst) begin
                cmp_rdata_a = '0;
                cmp_rdata_b = '0;
            end
            if (cmp_s.rv_a) cmp_rdata_a = cmp_s.rdata;
            if (cmp_s.rv_b) cmp_rdata_b = cmp_s.rdata;
            checkOutput("ctrl{gnt_a,gnt_b,err_a,err_b,rv_a,rv_b,cs,rd,wr}",
                        32'({gnt_a, gnt_b, err_a, err_b, rvalid_a, rvalid_b, ram_cs, ram_read, ram_write}),
                        32'({cmp_s.gnt_a, cmp_s.gnt_b, cmp_s.err_a, cmp_s.err_b, cmp_s.rv_a, cmp_s.rv_b,
                             cmp_s.cs, cmp_s.rd, cmp_s.wr}));
            if (cmp_s.cs) checkOutput("ram_addr", 32'(ram_addr), 32'(cmp_s.addr));
            if (cmp_s.cs && cmp_s.wr) checkOutput("ram_wdata", 32'(ram_wdata), 32'(cmp_s.wdata));
            checkOutput("rdata_a", 32'(rdata_a), 32'(cmp_rdata_a));
            checkOutput("rdata_b", 32'(rdata_b), 32'(cmp_rdata_b));
        end
    end

    // Event log used by the directed scenarios.
    bit         grant_log [$];
    logic [7:0] rv_a_data [$];
    logic [7:0] rv_b_data [$];
    int cnt_gnt_b = 0, cnt_err_b = 0, cnt_rv_a = 0, cnt_rv_b = 0, cnt_cs = 0;
    int last_gnt_a_cyc = 0, last_gnt_b_cyc = 0;
    always @(negedge clk) begin
        if (gnt_a) begin grant_log.push_back(1'b0); last_gnt_a_cyc = cyc; end
        if (gnt_b) begin grant_log.push_back(1'b1); last_gnt_b_cyc = cyc; cnt_gnt_b++; end
        if (err_b) cnt_err_b++;
        if (rvalid_a) begin rv_a_data.push_back(rdata_a); cnt_rv_a++; end
        if (rvalid_b) begin rv_b_data.push_back(rdata_b); cnt_rv_b++; end
        if (ram_cs) cnt_cs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit is_b, input bit we, input logic [7:0] addr,
                                 input logic [7:0] wdata, output bit got_err);
        bit done = 1'b0;
        got_err = 1'b0;
        if (is_b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
        else begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (is_b ? (gnt_b || err_b) : (gnt_a || err_a)) begin
                done    = 1'b1;
                got_err = is_b ? err_b : err_a;
            end
        end
        if (is_b) req_b = 1'b0;
        else req_a = 1'b0;
        if (!done) checkOutput(is_b ? "grant_timeout_b" : "grant_timeout_a", 32'(0), 32'(1));
    endtask

    task automatic waitRvalid(input bit is_b, output int at_cyc);
        bit done = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (is_b ? rvalid_b : rvalid_a) begin
                done   = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!done) checkOutput(is_b ? "rvalid_timeout_b" : "rvalid_timeout_a", 32'(0), 32'(1));
    endtask

    task automatic tieReads(input logic [7:0] a0, input logic [7:0] b0, input int n);
        fork
            begin
                bit e;
                for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, a0 + 8'(i), 8'h00, e);
            end
            begin
                bit e;
                for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, b0 + 8'(i), 8'h00, e);
            end
        join
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         e;
        int         issue, g, rc, base, ba, bb;
        int         s_cs, s_err_b, s_gnt_b, s_rv_b, s_rv_a;
        logic [5:0] pat;

        reset = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        repeat (3) tick();
        checkOutput("reset_pulses_and_ram_ctrl",
                    32'({gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, ram_cs, ram_read, ram_write}), 32'(0));
        checkOutput("reset_rdata", 32'({rdata_a, rdata_b}), 32'(0));
        reset = 1'b0;
        tick();

        $display("[TB] write then read on port A");
        applyStimulus(1'b0, 1'b1, 8'd3, 8'h5A, e);
        tick();
        issue = cyc;
        applyStimulus(1'b0, 1'b0, 8'd3, 8'h00, e);
        g = cyc;
        checkOutput("read_gnt_latency", 32'(g - issue), 32'(1));
        waitRvalid(1'b0, rc);
        checkOutput("read_rvalid_latency", 32'(rc - issue), 32'(3));
        checkOutput("read_back_5A", 32'(rdata_a), 32'h5A);

        $display("[TB] continuous tie after reset");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        base = grant_log.size();
        ba   = rv_a_data.size();
        bb   = rv_b_data.size();
        tieReads(8'd4, 8'd8, 3);
        checkOutput("tie_grant_count", 32'(grant_log.size() - base), 32'(6));
        pat = '0;
        for (int i = 0; i < 6; i++) pat[i] = grant_log[base + i];
        checkOutput("tie_grant_order", 32'(pat), 32'(6'b101010));
        checkOutput("tie_first_a_data", 32'(rv_a_data[ba]), 32'hA1);
        checkOutput("tie_first_b_data", 32'(rv_b_data[bb]), 32'hAD);

        $display("[TB] illegal address on port B");
        applyStimulus(1'b0, 1'b1, 8'd10, 8'h11, e);
        tick();
        s_cs = cnt_cs; s_err_b = cnt_err_b; s_gnt_b = cnt_gnt_b; s_rv_b = cnt_rv_b;
        applyStimulus(1'b1, 1'b0, 8'd32, 8'h00, e);
        checkOutput("illegal_got_err", 32'(e), 32'(1));
        repeat (3) tick();
        checkOutput("illegal_err_b_once", 32'(cnt_err_b - s_err_b), 32'(1));
        checkOutput("illegal_no_gnt_b", 32'(cnt_gnt_b - s_gnt_b), 32'(0));
        checkOutput("illegal_no_rvalid_b", 32'(cnt_rv_b - s_rv_b), 32'(0));
        checkOutput("illegal_no_ram_cs", 32'(cnt_cs - s_cs), 32'(0));
        base = grant_log.size();
        tieReads(8'd7, 8'd8, 1);
        checkOutput("err_moves_pointer_to_a", 32'(grant_log[base]), 32'(0));

        $display("[TB] reset during read wait");
        applyStimulus(1'b0, 1'b0, 8'd4, 8'h00, e);
        tick();
        reset = 1'b1;
        s_rv_a = cnt_rv_a;
        tick();
        checkOutput("midreset_outputs_zero",
                    32'({gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, ram_cs, ram_read, ram_write}), 32'(0));
        checkOutput("midreset_ram_bus_zero", 32'({ram_addr, ram_wdata}), 32'(0));
        checkOutput("midreset_rdata_a_zero", 32'(rdata_a), 32'(0));
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checkOutput("midreset_no_rvalid", 32'(cnt_rv_a - s_rv_a), 32'(0));
        base = grant_log.size();
        tieReads(8'd5, 8'd6, 1);
        checkOutput("midreset_next_tie_a", 32'(grant_log[base]), 32'(0));

        $display("[TB] late request from port B");
        fork
            begin
                bit e1;
                applyStimulus(1'b0, 1'b0, 8'd2, 8'h00, e1);
            end
            begin
                bit e2;
                bit seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    tick();
                    seen = gnt_a;
                end
                applyStimulus(1'b1, 1'b1, 8'd31, 8'hFF, e2);
            end
        join
        tick();
        checkOutput("late_gnt_b_delay", 32'(last_gnt_b_cyc - last_gnt_a_cyc), 32'(3));
        tick();
        applyStimulus(1'b1, 1'b0, 8'd31, 8'h00, e);
        waitRvalid(1'b1, rc);
        checkOutput("late_read_back_FF", 32'(rdata_b), 32'hFF);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
